// File: rtl/stopwatch_ctrl.sv
// Control FSM for the 6-digit BCD stopwatch: turns start/stop and lap/reset button levels
// into counter init/enable/latch controls, selects live or lap display, counts laps.
module stopwatch_ctrl #(
    parameter logic [23:0] MAX_COUNT = 24'h995999,
    parameter int unsigned LAP_MAX   = 9
) (
    input  logic        i_rtcclk,
    input  logic        i_reset_n,
    input  logic        i_tick,
    input  logic        i_btn_startstop,
    input  logic        i_btn_lapreset,
    input  logic [23:0] i_count,
    output logic        o_countinit,
    output logic        o_countenb,
    output logic        o_latchcount,
    output logic [23:0] o_display,
    output logic [3:0]  o_lap_cnt,
    output logic [1:0]  o_state,
    output logic        o_ovf
);

    localparam int unsigned CW = 24;
    localparam int unsigned LW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10,
        S_LAP  = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic           ss_q, lr_q;
    logic [CW-1:0]  lap_q, lap_d;
    logic [LW-1:0]  lapcnt_q, lapcnt_d;
    logic           ovf_q, ovf_d;
    logic           init_q, init_d;
    logic           latch_q, latch_d;

    logic ss_ev, lr_ev, at_max, counting;

    assign ss_ev    = i_btn_startstop & ~ss_q;
    assign lr_ev    = i_btn_lapreset & ~lr_q;
    assign at_max   = (i_count == MAX_COUNT);
    assign counting = (state_q == S_RUN) || (state_q == S_LAP);

    // Next-state and register-update logic; start/stop has priority over lap/reset
    always_comb begin
        state_d  = state_q;
        lap_d    = lap_q;
        lapcnt_d = lapcnt_q;
        ovf_d    = ovf_q;
        init_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ss_ev) state_d = S_RUN;
            end
            S_RUN: begin
                if (at_max && i_tick) begin
                    state_d = S_STOP;
                    ovf_d   = 1'b1;
                end else if (ss_ev) begin
                    state_d = S_STOP;
                end else if (lr_ev) begin
                    state_d = S_LAP;
                    lap_d   = i_count;
                    if (lapcnt_q < LW'(LAP_MAX)) lapcnt_d = lapcnt_q + LW'(1);
                end
            end
            S_LAP: begin
                if (at_max && i_tick) begin
                    state_d = S_STOP;
                    ovf_d   = 1'b1;
                end else if (ss_ev) begin
                    state_d = S_STOP;
                end else if (lr_ev) begin
                    state_d = S_RUN;
                end
            end
            S_STOP: begin
                if (ss_ev) begin
                    if (!ovf_q) state_d = S_RUN;
                end else if (lr_ev) begin
                    state_d  = S_IDLE;
                    init_d   = 1'b1;
                    lapcnt_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        latch_d = (state_d != S_LAP);
    end

    always_ff @(posedge i_rtcclk) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            ss_q     <= 1'b0;
            lr_q     <= 1'b0;
            lap_q    <= '0;
            lapcnt_q <= '0;
            ovf_q    <= 1'b0;
            init_q   <= 1'b0;
            latch_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ss_q     <= i_btn_startstop;
            lr_q     <= i_btn_lapreset;
            lap_q    <= lap_d;
            lapcnt_q <= lapcnt_d;
            ovf_q    <= ovf_d;
            init_q   <= init_d;
            latch_q  <= latch_d;
        end
    end

    // Enable is suppressed at full scale so the counter never wraps
    assign o_countenb   = i_tick & counting & ~at_max;
    assign o_countinit  = init_q;
    assign o_latchcount = latch_q;
    assign o_display    = (state_q == S_LAP) ? lap_q : i_count;
    assign o_lap_cnt    = lapcnt_q;
    assign o_state      = state_q;
    assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural BCD MM:SS:cc counter in the loop.
module tb_stopwatch_ctrl;

    logic        clk, rst_n, tick, btn_ss, btn_lr;
    logic [23:0] cnt;
    logic        countinit, countenb, latchcount, ovf;
    logic [23:0] display;
    logic [3:0]  lap_cnt;
    logic [1:0]  state;
    logic        ld;
    logic [23:0] ld_val;
    logic        enb_seen;
    int          n_chk, n_fail, enb_pulses, transitions;
    logic [1:0]  prev_state;

    stopwatch_ctrl dut (
        .i_rtcclk       (clk),
        .i_reset_n      (rst_n),
        .i_tick         (tick),
        .i_btn_startstop(btn_ss),
        .i_btn_lapreset (btn_lr),
        .i_count        (cnt),
        .o_countinit    (countinit),
        .o_countenb     (countenb),
        .o_latchcount   (latchcount),
        .o_display      (display),
        .o_lap_cnt      (lap_cnt),
        .o_state        (state),
        .o_ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[4*i +: 4] == lim) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Stopwatch counter model driven by the controller outputs
    always @(posedge clk) begin
        if (!rst_n)         cnt <= 24'h0;
        else if (ld)        cnt <= ld_val;
        else if (countinit) cnt <= 24'h0;
        else if (countenb)  cnt <= bcd_inc(cnt);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic ss, input logic lr, input logic tk);
        @(negedge clk);
        btn_ss = ss;
        btn_lr = lr;
        tick   = tk;
        #1;
        enb_seen = countenb;
        if (countenb) enb_pulses++;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [23:0] v);
        @(negedge clk);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        tick   = 1'b0;
        ld     = 1'b1;
        ld_val = v;
        @(posedge clk);
        #1;
        ld = 1'b0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n  = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        tick   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " state"}, 32'(state), 32'h0);
        chk({tag, " lap_cnt"}, 32'(lap_cnt), 32'h0);
        chk({tag, " ovf"}, 32'(ovf), 32'h0);
        chk({tag, " countinit"}, 32'(countinit), 32'h0);
        chk({tag, " latchcount"}, 32'(latchcount), 32'h1);
        chk({tag, " display"}, 32'(display), 32'(cnt));
    endtask

    typedef struct {
        logic       ss, lr, tick, enb;
        logic [1:0] st;
        logic       latch;
        logic [3:0] lap;
        logic       ovf, init;
    } vec_t;

    vec_t vecs[17];

    initial begin
        n_chk = 0; n_fail = 0; enb_pulses = 0; transitions = 0;
        rst_n = 1'b0; tick = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
        ld = 1'b0; ld_val = 24'h0; enb_seen = 1'b0;

        //          ss    lr    tick  enb   st     latch lap   ovf   init
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'd1, 1'b0, 1'b0};

        // Power-on reset
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_reset("por");
        chk("por countenb", 32'(enb_seen), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].ss, vecs[i].lr, vecs[i].tick);
            chk($sformatf("vec%0d countenb", i), 32'(enb_seen), 32'(vecs[i].enb));
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d latchcount", i), 32'(latchcount), 32'(vecs[i].latch));
            chk($sformatf("vec%0d lap_cnt", i), 32'(lap_cnt), 32'(vecs[i].lap));
            chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d countinit", i), 32'(countinit), 32'(vecs[i].init));
        end

        // 150 centisecond ticks from a fresh start
        rst_pulse();
        chk_reset("rst2");
        step(1'b1, 1'b0, 1'b0);
        enb_pulses = 0;
        for (int i = 0; i < 150; i++) step(1'b0, 1'b0, 1'b1);
        chk("run150 pulses", 32'(enb_pulses), 32'd150);
        chk("run150 display", 32'(display), 32'h000150);
        chk("run150 state", 32'(state), 32'h1);

        // Lap freezes display while the counter keeps advancing
        load(24'h001234);
        step(1'b0, 1'b1, 1'b0);
        chk("lap state", 32'(state), 32'h3);
        chk("lap display", 32'(display), 32'h001234);
        chk("lap lap_cnt", 32'(lap_cnt), 32'h1);
        chk("lap latchcount", 32'(latchcount), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        chk("lap display held", 32'(display), 32'h001234);
        chk("lap count live", 32'(cnt), 32'h001239);
        step(1'b0, 1'b1, 1'b0);
        chk("unlap state", 32'(state), 32'h1);
        chk("unlap latchcount", 32'(latchcount), 32'h1);
        chk("unlap display", 32'(display), 32'h001239);

        // Stop ignores ticks, lap/reset clears with a single init pulse
        step(1'b1, 1'b0, 1'b0);
        chk("stop state", 32'(state), 32'h2);
        enb_pulses = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk("stop pulses", 32'(enb_pulses), 32'd0);
        chk("stop count", 32'(cnt), 32'h001239);
        step(1'b0, 1'b1, 1'b0);
        chk("clear state", 32'(state), 32'h0);
        chk("clear init hi", 32'(countinit), 32'h1);
        chk("clear lap_cnt", 32'(lap_cnt), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("clear init lo", 32'(countinit), 32'h0);
        chk("clear display", 32'(display), 32'h0);

        // Full scale: no wrap, sticky overflow, start ignored
        step(1'b1, 1'b0, 1'b0);
        load(24'h995999);
        step(1'b0, 1'b0, 1'b1);
        chk("ovf countenb", 32'(enb_seen), 32'h0);
        chk("ovf state", 32'(state), 32'h2);
        chk("ovf flag", 32'(ovf), 32'h1);
        chk("ovf count", 32'(cnt), 32'h995999);
        step(1'b1, 1'b0, 1'b0);
        chk("ovf ss ignored", 32'(state), 32'h2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("ovf clear state", 32'(state), 32'h0);
        chk("ovf clear flag", 32'(ovf), 32'h0);
        chk("ovf clear init", 32'(countinit), 32'h1);

        // Held start/stop gives a single transition
        step(1'b0, 1'b0, 1'b0);
        prev_state = state;
        transitions = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (state != prev_state) transitions++;
            prev_state = state;
        end
        chk("held ss transitions", 32'(transitions), 32'd1);
        chk("held ss state", 32'(state), 32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Lap counter saturation
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("lap sat", 32'(lap_cnt), 32'd9);
        chk("lap sat state", 32'(state), 32'h1);

        // Reset mid-run
        rst_pulse();
        chk_reset("midrst");
        step(1'b0, 1'b0, 1'b1);
        chk("midrst countenb", 32'(enb_seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
